// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared RGB888 pixel definitions and per-pixel stream tags
package img_pkg;
   localparam int PIXEL_W = 24;
   localparam int R_LSB   = 16;
   localparam int G_LSB   = 8;
   localparam int B_LSB   = 0;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } pix_tag_t;

   localparam int TAG_W = $bits(pix_tag_t);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_DONE
   } strm_state_e;
endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry FIFO holding tagged pixels between frame-buffer read and output
module stream_fifo2 #(
   parameter int W = 27
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic [1:0]   count_o,
   output logic         empty_o,
   output logic         full_o
);
   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   count_q;
   logic         do_push;
   logic         do_pop;

   assign empty_o = (count_q == 2'd0);
   assign full_o  = (count_q == 2'd2);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign do_pop  = pop_i & ~empty_o;
   // At full, a push may reuse the slot freed by a same-cycle pop.
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end
endmodule

// File: rtl/rgb_frame_streamer.sv
// rtl/rgb_frame_streamer.sv - reads one frame from a sync-read frame buffer in raster order
// and streams it with sof/eol/eof markers under ready backpressure.
module rgb_frame_streamer
   import img_pkg::*;
#(
   parameter int IMG_W   = 64,
   parameter int IMG_H   = 64,
   parameter int ADDR_W  = 12,
   parameter int PIXEL_W = img_pkg::PIXEL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               mem_rd_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [PIXEL_W-1:0] mem_rdata,
   output logic [PIXEL_W-1:0] pixel_out,
   output logic               pixel_valid,
   input  logic               pixel_ready,
   output logic               sof,
   output logic               eol,
   output logic               eof,
   output logic               busy,
   output logic               done
);
   localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

   strm_state_e          state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [X_W-1:0]       x_q, x_d;
   logic [Y_W-1:0]       y_q, y_d;
   logic                 inflight_q;
   pix_tag_t             tag_q;
   pix_tag_t             issue_tag;
   pix_tag_t             head_tag;
   logic                 issue;
   logic                 pop;
   logic [1:0]           occ;
   logic                 fifo_empty;
   logic                 fifo_full;

   assign issue_tag.sof = (x_q == '0) && (y_q == '0);
   assign issue_tag.eol = (x_q == X_LAST);
   assign issue_tag.eof = (x_q == X_LAST) && (y_q == Y_LAST);

   assign pop = pixel_valid & pixel_ready;

   // Keep at most two pixels owned (buffered + in flight) after this cycle's pop.
   always_comb begin
      issue = 1'b0;
      if (state_q == ST_FETCH) begin
         if (fifo_full) issue = pop & ~inflight_q;
         else           issue = ({2'b0, inflight_q} + {1'b0, occ}) < (3'd2 + {2'b0, pop});
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               addr_d  = '0;
               x_d     = '0;
               y_d     = '0;
            end
         end
         ST_FETCH: begin
            if (issue) begin
               if (issue_tag.eof) begin
                  state_d = ST_DRAIN;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
                  if (issue_tag.eol) begin
                     x_d = '0;
                     y_d = y_q + Y_W'(1);
                  end else begin
                     x_d = x_q + X_W'(1);
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (pop && head_tag.eof) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         x_q        <= '0;
         y_q        <= '0;
         inflight_q <= 1'b0;
         tag_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         x_q        <= x_d;
         y_q        <= y_d;
         inflight_q <= issue;
         tag_q      <= issue_tag;
      end
   end

   stream_fifo2 #(
      .W(PIXEL_W + TAG_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (inflight_q),
      .data_i  ({tag_q, mem_rdata}),
      .pop_i   (pop),
      .data_o  ({head_tag, pixel_out}),
      .count_o (occ),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign mem_rd_en   = issue;
   assign mem_addr    = addr_q;
   assign pixel_valid = ~fifo_empty;
   assign sof         = pixel_valid & head_tag.sof;
   assign eol         = pixel_valid & head_tag.eol;
   assign eof         = pixel_valid & head_tag.eof;
   assign busy        = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   assign done        = (state_q == ST_DONE);
endmodule

// File: tb/tb_rgb_frame_streamer.sv
// tb/tb_rgb_frame_streamer.sv - directed bench for rgb_frame_streamer (4x2 and 1x1 frames)
module tb_rgb_frame_streamer;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, ready;
   logic        rd_en;
   logic [2:0]  addr;
   logic [23:0] rdata = '0;
   logic [23:0] pix;
   logic        valid, sof, eol, eof, busy, done;

   logic        start1, ready1;
   logic        rd_en1;
   logic [0:0]  addr1;
   logic [23:0] rdata1 = '0;
   logic [23:0] pix1;
   logic        valid1, sof1, eol1, eof1, busy1, done1;

   logic [23:0] mem0 [8];
   logic [23:0] mem1 [2];

   int n_vec = 0;
   int n_err = 0;
   int max_occ = 0;

   rgb_frame_streamer #(.IMG_W(4), .IMG_H(2), .ADDR_W(3), .PIXEL_W(24)) u_dut (
      .clk(clk), .rst(rst), .start(start), .mem_rd_en(rd_en), .mem_addr(addr),
      .mem_rdata(rdata), .pixel_out(pix), .pixel_valid(valid), .pixel_ready(ready),
      .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
   );

   rgb_frame_streamer #(.IMG_W(1), .IMG_H(1), .ADDR_W(1), .PIXEL_W(24)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .mem_rd_en(rd_en1), .mem_addr(addr1),
      .mem_rdata(rdata1), .pixel_out(pix1), .pixel_valid(valid1), .pixel_ready(ready1),
      .sof(sof1), .eol(eol1), .eof(eof1), .busy(busy1), .done(done1)
   );

   always @(posedge clk) begin
      if (rd_en)  rdata  <= mem0[addr];
      if (rd_en1) rdata1 <= mem1[addr1];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] st0();
      return {rd_en, valid, sof, eol, eof, done, busy};
   endfunction

   function automatic logic [6:0] st1();
      return {rd_en1, valid1, sof1, eol1, eof1, done1, busy1};
   endfunction

   // mode 0: ready=1; mode 1: ready 1010... with a 5-cycle low gap; mode 2: ready=1 plus stray starts
   task automatic run_frame(input bit do_start, input int mode, input string tag);
      int          idx = 0;
      int          ndone = 0;
      bit          prev_stall = 0;
      logic [23:0] prev_data = '0;
      if (do_start) begin
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
      end
      for (int cyc = 0; cyc < 200 && ndone == 0; cyc++) begin
         @(negedge clk);
         case (mode)
            1:       ready = (cyc >= 10 && cyc < 15) ? 1'b0 : ((cyc % 2) == 0);
            default: ready = 1'b1;
         endcase
         start = (mode == 2 && cyc == 4);
         #1;
         if (int'(u_dut.u_fifo.count_o) > max_occ) max_occ = int'(u_dut.u_fifo.count_o);
         if (prev_stall)
            chk($sformatf("%s_stall%0d", tag, idx), {valid, pix}, {1'b1, prev_data});
         if (valid && ready) begin
            chk($sformatf("%s_data%0d", tag, idx), pix, idx * 24'h010203);
            chk($sformatf("%s_tag%0d", tag, idx), {sof, eol, eof},
                {idx == 0, (idx % 4) == 3, idx == 7});
            idx++;
         end
         prev_stall = valid && !ready;
         prev_data  = pix;
         if (done) begin
            ndone++;
            if (mode == 2) start = 1'b1;
         end
      end
      chk({tag, "_count"}, idx, 8);
      chk({tag, "_done"}, ndone, 1);
   endtask

   initial begin
      logic [6:0] exp;
      int         n;
      bit         bad;
      rst = 1'b1; start = 1'b0; ready = 1'b1; start1 = 1'b0; ready1 = 1'b1;
      for (int i = 0; i < 8; i++) mem0[i] = 24'(i) * 24'h010203;
      mem1[0] = 24'hABCDEF;
      mem1[1] = 24'h000000;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // 1: reset mid-idle
      repeat (2) @(negedge clk);
      rst = 1'b1; #1;
      chk("t1_status", st0(), 7'd0);
      chk("t1_pix", pix, 24'd0);
      chk("t1_status1", st1(), 7'd0);
      @(negedge clk); rst = 1'b0; #1;
      chk("t1_idle", st0(), 7'd0);

      // 2: cycle-exact 4x2 frame with ready=1; start sampled in cycle 0
      @(negedge clk); start = 1'b1;
      for (int c = 0; c <= 12; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 1) start = 1'b0;
         #1;
         exp = {c >= 1 && c <= 8, c >= 3 && c <= 10, c == 3, c == 6 || c == 10,
                c == 10, c == 11, c >= 1 && c <= 10};
         chk($sformatf("t2_st_c%0d", c), st0(), exp);
         if (c >= 1 && c <= 8) chk($sformatf("t2_addr_c%0d", c), addr, c - 1);
         if (c >= 3 && c <= 10) chk($sformatf("t2_data_c%0d", c), pix, (c - 3) * 24'h010203);
      end

      // 3: toggling ready with a 5-cycle stall
      max_occ = 0;
      run_frame(1'b1, 1, "t3");
      chk("t3_occ_le2", max_occ <= 2, 1);

      // 4: starts during busy and on done ignored; start one cycle after done restarts
      run_frame(1'b1, 2, "t4");
      @(negedge clk); #1;
      chk("t4_done_start_ign", {rd_en, busy, done}, 3'b000);
      @(negedge clk); start = 1'b0; #1;
      chk("t4_restart", {rd_en, busy}, 2'b11);
      chk("t4_restart_addr", addr, 3'd0);
      run_frame(1'b0, 0, "t4b");

      // 5: reset after three transfers
      @(negedge clk); start = 1'b1; ready = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      for (int k = 0; k < 20 && n < 3; k++) begin
         @(negedge clk); #1;
         if (valid && ready) n++;
      end
      chk("t5_xfers", n, 3);
      @(negedge clk); rst = 1'b1; #1;
      chk("t5_rst_status", st0(), 7'd0);
      chk("t5_rst_pix", pix, 24'd0);
      @(negedge clk); rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         if (valid || done || busy || rd_en) bad = 1;
      end
      chk("t5_quiet", bad, 0);
      run_frame(1'b1, 0, "t5b");

      // 6: 1x1 frame
      @(negedge clk); start1 = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 1) start1 = 1'b0;
         #1;
         exp = {c == 1, c == 3, c == 3, c == 3, c == 3, c == 4, c >= 1 && c <= 3};
         chk($sformatf("t6_st_c%0d", c), st1(), exp);
         if (c == 3) chk("t6_data", pix1, 24'hABCDEF);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
